// File: rtl/sieve_marker.sv
// Sieve-of-Eratosthenes writer for a 1-bit BoolRam: clears [2, lmax], then marks the multiples of each prime as 1.
// Optional build macro SIEVE_ODD_STEP_EN: after p=2, test only odd p and mark only odd multiples.
module sieve_marker #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] max_prime,
    input  logic              bool_ram_q,
    output logic [ADDR_W-1:0] bool_ram_addr,
    output logic              bool_ram_data,
    output logic              bool_ram_wren,
    output logic              busy,
    output logic              done_sieving
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_READ, S_EVAL, S_MARK, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   lmax, lmax_n;
    logic [ADDR_W-1:0]   a, a_n;
    logic [ADDR_W-1:0]   p, p_n;
    logic [ADDR_W:0]     m, m_n;

    logic [ADDR_W:0]     step;
    logic [ADDR_W-1:0]   pinc;
    logic [ADDR_W-1:0]   p_adv;
    logic [ADDR_W:0]     m_step;
    logic [2*ADDR_W-1:0] sq_cur;
    logic [2*ADDR_W-1:0] sq_adv;
    logic                adv_done;
    logic                unused_sq_hi;

    always_comb begin
`ifdef SIEVE_ODD_STEP_EN
        if (p == ADDR_W'(2)) begin
            step = {1'b0, p};
            pinc = ADDR_W'(1);
        end else begin
            step = {p, 1'b0};
            pinc = ADDR_W'(2);
        end
`else
        step = {1'b0, p};
        pinc = ADDR_W'(1);
`endif
    end

    // Squares are formed at full width so the termination test never wraps.
    assign sq_cur       = {{ADDR_W{1'b0}}, p} * {{ADDR_W{1'b0}}, p};
    assign p_adv        = p + pinc;
    assign sq_adv       = {{ADDR_W{1'b0}}, p_adv} * {{ADDR_W{1'b0}}, p_adv};
    assign adv_done     = sq_adv > {{ADDR_W{1'b0}}, lmax};
    assign m_step       = m + step;
    assign unused_sq_hi = ^sq_cur[2*ADDR_W-1:ADDR_W+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            lmax  <= '0;
            a     <= '0;
            p     <= ADDR_W'(2);
            m     <= '0;
        end else begin
            state <= state_n;
            lmax  <= lmax_n;
            a     <= a_n;
            p     <= p_n;
            m     <= m_n;
        end
    end

    always_comb begin
        state_n       = state;
        lmax_n        = lmax;
        a_n           = a;
        p_n           = p;
        m_n           = m;
        bool_ram_addr = '0;
        bool_ram_data = 1'b0;
        bool_ram_wren = 1'b0;
        busy          = 1'b0;
        done_sieving  = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                done_sieving = (state == S_DONE);
                if (start) begin
                    lmax_n  = max_prime;
                    a_n     = ADDR_W'(2);
                    state_n = (max_prime < ADDR_W'(2)) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy          = 1'b1;
                bool_ram_addr = a;
                bool_ram_wren = 1'b1;
                if (a == lmax) begin
                    p_n     = ADDR_W'(2);
                    state_n = (lmax < ADDR_W'(4)) ? S_DONE : S_READ;
                end else begin
                    a_n = a + ADDR_W'(1);
                end
            end
            S_READ: begin
                busy          = 1'b1;
                bool_ram_addr = p;
                state_n       = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                if (!bool_ram_q) begin
                    m_n     = sq_cur[ADDR_W:0];
                    state_n = S_MARK;
                end else begin
                    p_n     = p_adv;
                    state_n = adv_done ? S_DONE : S_READ;
                end
            end
            S_MARK: begin
                busy          = 1'b1;
                bool_ram_addr = m[ADDR_W-1:0];
                bool_ram_data = 1'b1;
                bool_ram_wren = 1'b1;
                if (m_step > {1'b0, lmax}) begin
                    p_n     = p_adv;
                    state_n = adv_done ? S_DONE : S_READ;
                end else begin
                    m_n = m_step;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sieve_marker.sv
// Scoreboard bench for sieve_marker: each run queues its expected outcome, a monitor checks it when done_sieving rises.
module tb_sieve_marker;
    localparam int AW = 10;

`ifdef SIEVE_ODD_STEP_EN
    localparam int M30  = 19;
    localparam int M100 = 77;
`else
    localparam int M30  = 24;
    localparam int M100 = 104;
`endif

    typedef struct {
        int lmax;
        int zeros;
        int clear_w;
        int mark_w;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] max_prime = '0;
    logic          bool_ram_q;
    logic [AW-1:0] bool_ram_addr;
    logic          bool_ram_data;
    logic          bool_ram_wren;
    logic          busy;
    logic          done_sieving;

    logic          mem [0:1023];
    logic          q_r = 1'b0;
    logic          ram_fill = 1'b1;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cur_lmax = 0;
    int            clear_cnt = 0;
    int            mark_cnt = 0;
    int            bad_cnt = 0;
    logic          done_prev = 1'b0;

    always #5 clk = ~clk;

    sieve_marker #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .max_prime     (max_prime),
        .bool_ram_q    (bool_ram_q),
        .bool_ram_addr (bool_ram_addr),
        .bool_ram_data (bool_ram_data),
        .bool_ram_wren (bool_ram_wren),
        .busy          (busy),
        .done_sieving  (done_sieving)
    );

    assign bool_ram_q = q_r;

    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 1'b1;
        end else if (bool_ram_wren) begin
            mem[bool_ram_addr] <= bool_ram_data;
        end else begin
            q_r <= mem[bool_ram_addr];
        end
    end

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: counts writes, and on each rising done_sieving scores the RAM against the queued expectation.
    initial begin
        exp_t e;
        int   zeros;
        int   mism;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                clear_cnt = 0;
                mark_cnt  = 0;
                bad_cnt   = 0;
            end else begin
                if (bool_ram_wren) begin
                    if (bool_ram_data) mark_cnt++;
                    else clear_cnt++;
                    if (int'(bool_ram_addr) < 2 || int'(bool_ram_addr) > cur_lmax) bad_cnt++;
                end
                if (done_sieving && !done_prev) begin
                    chk("expectation_queued", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        zeros = 0;
                        mism  = 0;
                        for (int i = 2; i <= e.lmax; i++) begin
                            if (mem[i] == 1'b0) zeros++;
                            if (mem[i] == is_prime(i)) mism++;
                        end
                        chk($sformatf("zeros_max%0d", e.lmax), zeros, e.zeros);
                        chk($sformatf("bitmap_max%0d", e.lmax), mism, 0);
                        chk($sformatf("clear_writes_max%0d", e.lmax), clear_cnt, e.clear_w);
                        if (e.mark_w >= 0)
                            chk($sformatf("mark_writes_max%0d", e.lmax), mark_cnt, e.mark_w);
                        chk($sformatf("bad_addr_writes_max%0d", e.lmax), bad_cnt, 0);
                        chk($sformatf("busy_at_done_max%0d", e.lmax), int'(busy), 0);
                    end
                    clear_cnt = 0;
                    mark_cnt  = 0;
                    bad_cnt   = 0;
                end
            end
            done_prev = done_sieving;
        end
    end

    task automatic pulse_start(input int mp);
        @(negedge clk);
        max_prime = AW'(mp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(done_sieving && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished_in_budget"}, int'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_mark(input string name, input int budget);
        int n = 0;
        while (!(bool_ram_wren && bool_ram_data) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_mark_seen"}, int'(n < budget), 1);
    endtask

    task automatic queue_run(input int mp, input int zeros, input int cw, input int mw);
        exp_t e;
        e.lmax = mp;
        e.zeros = zeros;
        e.clear_w = cw;
        e.mark_w = mw;
        exp_q.push_back(e);
        cur_lmax = mp;
    endtask

    task automatic run(input int mp, input int zeros, input int cw, input int mw, input int budget);
        queue_run(mp, zeros, cw, mw);
        pulse_start(mp);
        wait_done($sformatf("run_max%0d", mp), budget);
    endtask

    initial begin
        ram_fill = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        ram_fill = 1'b0;
        chk("reset_wren", int'(bool_ram_wren), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done_sieving), 0);
        chk("reset_addr", int'(bool_ram_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // max_prime=1: straight to DONE one cycle after start, no writes
        queue_run(1, 0, 0, 0);
        pulse_start(1);
        chk("max1_done_next_cycle", int'(done_sieving), 1);
        chk("max1_not_busy", int'(busy), 0);
        @(negedge clk);

        run(30, 10, 29, M30, 2000);
        run(1023, 172, 1022, -1, 20000);
        run(3, 2, 2, 0, 200);
        run(4, 2, 3, 1, 200);

        // start during MARK must be ignored
        queue_run(30, 10, 29, M30);
        pulse_start(30);
        wait_mark("stray", 500);
        pulse_start(5);
        chk("stray_still_busy", int'(busy), 1);
        wait_done("run_stray", 2000);
        run(10, 4, 9, 5, 500);

        // reset in the middle of MARK
        cur_lmax = 100;
        pulse_start(100);
        wait_mark("abort", 1000);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_wren", int'(bool_ram_wren), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done_sieving), 0);
        chk("midreset_addr", int'(bool_ram_addr), 0);
        reset = 1'b0;
        @(negedge clk);
        run(30, 10, 29, M30, 2000);

        run(100, 25, 99, M100, 3000);

        repeat (5) @(negedge clk);
        chk("leftover_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
